// File: rtl/hht_pkg.sv
// hht_pkg: shared definitions for the HHT sparse-gather sequencer.
//   DW, RA_W      default data/address and register-address widths
//   COL_BASE_REG  register index holding the column-index base address
//   VAL_BASE_REG  register index holding the vector base address
//   state_t       sequencer states
package hht_pkg;

  localparam int unsigned DW           = 32;
  localparam int unsigned RA_W         = 5;
  localparam int unsigned COL_BASE_REG = 6;
  localparam int unsigned VAL_BASE_REG = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_CBASE,
    RD_VBASE,
    STREAM,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/hht_gather_sched_if.sv
// hht_gather_sched_if: control, register, memory and output-stream signals of
// the gather sequencer.
//   slave  : sequencer side (drives regaddr, rd1/addr1, rd2/addr2, out_*, busy, done)
//   master : environment side (drives start/csize, reg_rdata, dataIn1/2, out_ready)
interface hht_gather_sched_if #(
  parameter int unsigned DW   = 32,
  parameter int unsigned RA_W = 5
);
  logic            start;
  logic [DW-1:0]   csize;
  logic [RA_W-1:0] regaddr;
  logic [DW-1:0]   reg_rdata;
  logic            rd1;
  logic [DW-1:0]   addr1;
  logic [DW-1:0]   dataIn1;
  logic            rd2;
  logic [DW-1:0]   addr2;
  logic [DW-1:0]   dataIn2;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [DW-1:0]   out_idx;
  logic            out_ready;
  logic            busy;
  logic            done;

  modport slave (
    input  start, csize, reg_rdata, dataIn1, dataIn2, out_ready,
    output regaddr, rd1, addr1, rd2, addr2, out_valid, out_data, out_idx, busy, done
  );

  modport master (
    output start, csize, reg_rdata, dataIn1, dataIn2, out_ready,
    input  regaddr, rd1, addr1, rd2, addr2, out_valid, out_data, out_idx, busy, done
  );
endinterface

// File: rtl/hht_sync_fifo.sv
// hht_sync_fifo: synchronous FIFO, DEPTH a power of two.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write strobe / data (a push while full is dropped unless popping)
//   pop        : read strobe (ignored while empty)
//   dout       : head entry
//   count      : number of stored entries (0..DEPTH)
module hht_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [WIDTH-1:0]        din,
  input  logic                    pop,
  output logic [WIDTH-1:0]        dout,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/hht_gather_sched.sv
// hht_gather_sched: sequencer for the HHT sparse-gather datapath.
// On start it reads the column-index base (reg 6) and vector base (reg 8),
// streams csize column indices on port 1, issues dependent gathers on port 2
// (addr2 = v_base + col_idx) and queues {index, value} in an output FIFO.
//   Clk, Rst      : clock, asynchronous active-low reset
//   bus (slave)   : start/csize, register port, memory ports 1/2, output stream,
//                   busy, done (see hht_gather_sched_if)
//   perf_stall    : only with HHT_PERF_EN defined; STREAM cycles in which the
//                   column-index stage was blocked by backpressure (saturating,
//                   cleared when a start is accepted)
module hht_gather_sched
  import hht_pkg::*;
#(
  parameter int unsigned DW         = hht_pkg::DW,
  parameter int unsigned RA_W       = hht_pkg::RA_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic          Clk,
  input  logic          Rst,
  hht_gather_sched_if.slave bus
`ifdef HHT_PERF_EN
  ,
  output logic [DW-1:0] perf_stall
`endif
);
  localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

  state_t          state;
  logic [DW-1:0]   col_base;
  logic [DW-1:0]   v_base;
  logic [DW-1:0]   cnt;
  logic [DW-1:0]   i_q;
  logic [DW-1:0]   addr1_q;
  logic [DW-1:0]   addr2_q;
  logic            s2_valid;
  logic [DW-1:0]   s2_col;
  logic [DW-1:0]   s2_idx;
  logic [RA_W-1:0] regaddr_q;
  logic            done_q;

  logic [CW-1:0]   fifo_count;
  logic [2*DW-1:0] fifo_dout;
  logic [CW:0]     occupancy;
  logic            space;
  logic            s1_issue;
  logic            pop;
  logic [DW-1:0]   addr1_cur;
  logic [DW-1:0]   addr2_cur;

  // Entries already stored plus the one in flight in S2 must leave a free
  // slot, so the FIFO can never overflow even though S2 never stalls.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, s2_valid};
  assign space     = occupancy < DEPTH_L;
  assign s1_issue  = (state == STREAM) && space;
  assign pop       = bus.out_valid && bus.out_ready;
  assign addr1_cur = col_base + i_q;
  assign addr2_cur = v_base + s2_col;

  // Memory data returns combinationally, so strobes/addresses are presented
  // in the issuing cycle; the addresses hold their last value otherwise.
  assign bus.rd1       = s1_issue;
  assign bus.addr1     = s1_issue ? addr1_cur : addr1_q;
  assign bus.rd2       = s2_valid;
  assign bus.addr2     = s2_valid ? addr2_cur : addr2_q;
  assign bus.regaddr   = regaddr_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.out_valid = (fifo_count != '0);
  assign bus.out_idx   = fifo_dout[2*DW-1:DW];
  assign bus.out_data  = fifo_dout[DW-1:0];

  hht_sync_fifo #(
    .WIDTH (2 * DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (Clk),
    .rst_n (Rst),
    .push  (s2_valid),
    .din   ({s2_idx, bus.dataIn2}),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      col_base  <= '0;
      v_base    <= '0;
      cnt       <= '0;
      i_q       <= '0;
      addr1_q   <= '0;
      addr2_q   <= '0;
      s2_valid  <= 1'b0;
      s2_col    <= '0;
      s2_idx    <= '0;
      regaddr_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      s2_valid <= s1_issue;
      if (s1_issue) begin
        addr1_q <= addr1_cur;
        s2_col  <= bus.dataIn1;
        s2_idx  <= i_q;
        i_q     <= i_q + DW'(1);
      end
      if (s2_valid) addr2_q <= addr2_cur;

      case (state)
        IDLE: begin
          if (bus.start) begin
            cnt       <= bus.csize;
            i_q       <= '0;
            regaddr_q <= RA_W'(COL_BASE_REG);
            state     <= RD_CBASE;
          end
        end
        RD_CBASE: begin
          col_base  <= bus.reg_rdata;
          regaddr_q <= RA_W'(VAL_BASE_REG);
          state     <= RD_VBASE;
        end
        RD_VBASE: begin
          v_base <= bus.reg_rdata;
          state  <= (cnt == '0) ? DONE : STREAM;
        end
        STREAM: begin
          if (s1_issue && (i_q == cnt - DW'(1))) state <= DRAIN;
        end
        DRAIN: begin
          if (!s2_valid && (fifo_count == '0)) state <= DONE;
        end
        DONE: begin
          // done is registered, so the pulse appears as the FSM returns to IDLE
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HHT_PERF_EN
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      perf_stall <= '0;
    end else if ((state == IDLE) && bus.start) begin
      perf_stall <= '0;
    end else if ((state == STREAM) && !space && (perf_stall != '1)) begin
      perf_stall <= perf_stall + DW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hht_gather_sched.sv
// Self-checking bench for hht_gather_sched. A background monitor compares each
// accepted output against a queue of expected {idx, data} pairs; scenario
// tasks check latency, strobe counts, address sequences and done/busy timing.
// perf_stall checks are compiled in when HHT_PERF_EN is defined.
module tb_hht_gather_sched;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  hht_gather_sched_if #(.DW(32), .RA_W(5)) bus ();

  logic [31:0] col_base_val = 32'd180;
`ifdef HHT_PERF_EN
  logic [31:0] perf_stall;
`endif

  hht_gather_sched #(
    .DW         (32),
    .RA_W       (5),
    .FIFO_DEPTH (4)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.slave)
`ifdef HHT_PERF_EN
    ,
    .perf_stall (perf_stall)
`endif
  );

  int passed = 0;
  int total  = 0;
  int rd1_cnt  = 0;
  int done_cnt = 0;
  logic [63:0] exp_q [$];
  logic [31:0] addr1_log [$];
  logic [31:0] addr2_log [$];

  function automatic logic [31:0] p1(input logic [31:0] a);
    case (a)
      32'd180:       return 32'd5;
      32'd181:       return 32'd15;
      32'd182:       return 32'd6;
      32'd183:       return 32'd12;
      32'hFFFF_FFFF: return 32'd5;
      32'd0:         return 32'd15;
      default:       return {28'd0, a[3:0]} + 32'd20;
    endcase
  endfunction

  function automatic logic [31:0] p2(input logic [31:0] a);
    case (a)
      32'd7:   return 32'd98;
      32'd8:   return 32'd27;
      32'd14:  return 32'd94;
      32'd17:  return 32'd36;
      default: return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  assign bus.dataIn1   = p1(bus.addr1);
  assign bus.dataIn2   = p2(bus.addr2);
  assign bus.reg_rdata = (bus.regaddr == 5'd6) ? col_base_val :
                         (bus.regaddr == 5'd8) ? 32'd2 : 32'd0;

  // Scoreboard monitor and event logs.
  always @(negedge Clk) begin
    if (Rst) begin
      if (bus.rd1) begin
        rd1_cnt++;
        addr1_log.push_back(bus.addr1);
      end
      if (bus.rd2) addr2_log.push_back(bus.addr2);
      if (bus.done) done_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected got idx=%0d data=%0d required no output", bus.out_idx, bus.out_data);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          if ({bus.out_idx, bus.out_data} !== e)
            $display("FAIL sb_data got idx=%0d data=%0d required idx=%0d data=%0d",
                     bus.out_idx, bus.out_data, e[63:32], e[31:0]);
          else passed++;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic expect_run(input logic [31:0] cbase, input logic [31:0] vbase, input int unsigned n);
    for (int unsigned i = 0; i < n; i++)
      exp_q.push_back({32'(i), p2(vbase + p1(cbase + 32'(i)))});
  endtask

  task automatic expect_test1;
    exp_q.push_back({32'd0, 32'd98});
    exp_q.push_back({32'd1, 32'd36});
    exp_q.push_back({32'd2, 32'd27});
    exp_q.push_back({32'd3, 32'd94});
  endtask

  task automatic clear_logs;
    rd1_cnt  = 0;
    done_cnt = 0;
    addr1_log.delete();
    addr2_log.delete();
  endtask

  // Returns 1 ns after the edge that samples start.
  task automatic do_start(input logic [31:0] n);
    @(posedge Clk);
    #1 bus.start = 1'b1;
    bus.csize = n;
    @(posedge Clk);
    #1 bus.start = 1'b0;
    bus.csize = 32'd99;
  endtask

  task automatic wait_done(input int budget, input string name);
    int base;
    int k;
    base = done_cnt;
    k = 0;
    while (done_cnt == base && k < budget) begin
      @(negedge Clk);
      k++;
    end
    if (done_cnt == base) begin
      total++;
      $display("FAIL %s_timeout got no done in %0d cycles required done pulse", name, budget);
    end
  endtask

  task automatic test_reset;
    bus.start = 1'b0;
    bus.csize = 32'd0;
    bus.out_ready = 1'b0;
    #12;
    total++;
    if ({bus.busy, bus.done, bus.rd1, bus.rd2, bus.out_valid} !== 5'b0)
      $display("FAIL rst_flags got %b required 00000", {bus.busy, bus.done, bus.rd1, bus.rd2, bus.out_valid});
    else passed++;
    total++;
    if (bus.regaddr !== 5'd0) $display("FAIL rst_regaddr got %0d required 0", bus.regaddr);
    else passed++;
    total++;
    if (bus.addr1 !== 32'd0) $display("FAIL rst_addr1 got %0d required 0", bus.addr1);
    else passed++;
    total++;
    if (bus.addr2 !== 32'd0) $display("FAIL rst_addr2 got %0d required 0", bus.addr2);
    else passed++;
    total++;
    if ({bus.out_idx, bus.out_data} !== 64'd0)
      $display("FAIL rst_out got idx=%0d data=%0d required 0/0", bus.out_idx, bus.out_data);
    else passed++;
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  task automatic test_basic;
    logic [31:0] exp_a2 [4];
    exp_a2 = '{32'd7, 32'd17, 32'd8, 32'd14};
    clear_logs();
    bus.out_ready = 1'b1;
    expect_test1();
    do_start(32'd4);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    total++;
    if (bus.out_valid !== 1'b0) $display("FAIL basic_latency_e3 got out_valid=%b required 0", bus.out_valid);
    else passed++;
    @(posedge Clk);
    @(negedge Clk);
    total++;
    if (bus.out_valid !== 1'b1) $display("FAIL basic_latency_e4 got out_valid=%b required 1", bus.out_valid);
    else passed++;
    wait_done(60, "basic");
    repeat (3) @(negedge Clk);
    total++;
    if (done_cnt !== 1) $display("FAIL basic_done_count got %0d required 1", done_cnt);
    else passed++;
    total++;
    if (rd1_cnt !== 4) $display("FAIL basic_rd1_count got %0d required 4", rd1_cnt);
    else passed++;
    total++;
    if (addr2_log.size() !== 4) $display("FAIL basic_addr2_count got %0d required 4", addr2_log.size());
    else begin
      passed++;
      for (int i = 0; i < 4; i++) begin
        total++;
        if (addr2_log[i] !== exp_a2[i])
          $display("FAIL basic_addr2_%0d got %0d required %0d", i, addr2_log[i], exp_a2[i]);
        else passed++;
      end
    end
    total++;
    if (exp_q.size() !== 0) $display("FAIL basic_sb_left got %0d required 0", exp_q.size());
    else passed++;
    total++;
    if (bus.busy !== 1'b0) $display("FAIL basic_busy_end got %b required 0", bus.busy);
    else passed++;
  endtask

  // csize=6 with the consumer stalled: port 1 must stop once the FIFO plus the
  // in-flight gather fill all four slots, then resume with no lost entries.
  task automatic test_backpressure;
    clear_logs();
    bus.out_ready = 1'b0;
    expect_run(32'd180, 32'd2, 6);
    do_start(32'd6);
    repeat (20) @(posedge Clk);
    #1;
    total++;
    if (rd1_cnt !== 4) $display("FAIL bp_rd1_stalled got %0d required 4", rd1_cnt);
    else passed++;
    total++;
    if ({bus.busy, bus.out_valid, bus.rd1} !== 3'b110)
      $display("FAIL bp_stall_flags got %b required 110", {bus.busy, bus.out_valid, bus.rd1});
    else passed++;
    total++;
    if (done_cnt !== 0) $display("FAIL bp_early_done got %0d required 0", done_cnt);
    else passed++;
    bus.out_ready = 1'b1;
    wait_done(80, "bp");
    repeat (2) @(negedge Clk);
    total++;
    if (rd1_cnt !== 6) $display("FAIL bp_rd1_total got %0d required 6", rd1_cnt);
    else passed++;
    total++;
    if (done_cnt !== 1) $display("FAIL bp_done_count got %0d required 1", done_cnt);
    else passed++;
    total++;
    if (exp_q.size() !== 0) $display("FAIL bp_sb_left got %0d required 0", exp_q.size());
    else passed++;
`ifdef HHT_PERF_EN
    total++;
    if (perf_stall !== 32'd15) $display("FAIL perf_stall_window got %0d required 15", perf_stall);
    else passed++;
`endif
  endtask

`ifdef HHT_PERF_EN
  task automatic test_perf_clear;
    clear_logs();
    do_start(32'd0);
    @(negedge Clk);
    total++;
    if (perf_stall !== 32'd0) $display("FAIL perf_clear got %0d required 0", perf_stall);
    else passed++;
    wait_done(20, "perf");
    @(negedge Clk);
  endtask
`endif

  task automatic test_zero;
    clear_logs();
    do_start(32'd0);
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    total++;
    if ({bus.done, bus.busy} !== 2'b01) $display("FAIL zero_e2 got done,busy=%b required 01", {bus.done, bus.busy});
    else passed++;
    @(posedge Clk);
    @(negedge Clk);
    total++;
    if ({bus.done, bus.busy} !== 2'b10) $display("FAIL zero_e3 got done,busy=%b required 10", {bus.done, bus.busy});
    else passed++;
    @(negedge Clk);
    total++;
    if (bus.done !== 1'b0) $display("FAIL zero_pulse_width got done=%b required 0", bus.done);
    else passed++;
    total++;
    if ((rd1_cnt + addr2_log.size()) !== 0)
      $display("FAIL zero_strobes got %0d required 0", rd1_cnt + addr2_log.size());
    else passed++;
  endtask

  task automatic test_abort;
    logic [31:0] exp_a2 [4];
    exp_a2 = '{32'd7, 32'd17, 32'd8, 32'd14};
    clear_logs();
    bus.out_ready = 1'b1;
    expect_run(32'd180, 32'd2, 4);
    do_start(32'd4);
    repeat (4) @(posedge Clk);
    #2 Rst = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.done, bus.rd1, bus.rd2, bus.out_valid} !== 5'b0)
      $display("FAIL abort_flags got %b required 00000", {bus.busy, bus.done, bus.rd1, bus.rd2, bus.out_valid});
    else passed++;
    total++;
    if ({bus.addr1, bus.addr2} !== 64'd0)
      $display("FAIL abort_addrs got %0d/%0d required 0/0", bus.addr1, bus.addr2);
    else passed++;
    total++;
    if (bus.regaddr !== 5'd0) $display("FAIL abort_regaddr got %0d required 0", bus.regaddr);
    else passed++;
    exp_q.delete();
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    total++;
    if (done_cnt !== 0) $display("FAIL abort_no_done got %0d required 0", done_cnt);
    else passed++;
    clear_logs();
    expect_test1();
    do_start(32'd4);
    wait_done(60, "restart");
    repeat (2) @(negedge Clk);
    total++;
    if (addr2_log.size() !== 4) $display("FAIL restart_addr2_count got %0d required 4", addr2_log.size());
    else begin
      passed++;
      for (int i = 0; i < 4; i++) begin
        total++;
        if (addr2_log[i] !== exp_a2[i])
          $display("FAIL restart_addr2_%0d got %0d required %0d", i, addr2_log[i], exp_a2[i]);
        else passed++;
      end
    end
    total++;
    if (exp_q.size() !== 0) $display("FAIL restart_sb_left got %0d required 0", exp_q.size());
    else passed++;
  endtask

  // A second start lands while busy and reg 6 changes mid-run; neither may
  // affect the run, and addr1 must wrap from all-ones to zero.
  task automatic test_busy_wrap;
    clear_logs();
    bus.out_ready = 1'b1;
    col_base_val = 32'hFFFF_FFFF;
    exp_q.push_back({32'd0, 32'd98});
    exp_q.push_back({32'd1, 32'd36});
    do_start(32'd2);
    @(posedge Clk);
    @(posedge Clk);
    #1 bus.start = 1'b1;
    bus.csize = 32'd7;
    col_base_val = 32'd180;
    @(posedge Clk);
    #1 bus.start = 1'b0;
    wait_done(60, "wrap");
    repeat (6) @(negedge Clk);
    total++;
    if (done_cnt !== 1) $display("FAIL wrap_done_count got %0d required 1", done_cnt);
    else passed++;
    total++;
    if (addr1_log.size() !== 2) $display("FAIL wrap_addr1_count got %0d required 2", addr1_log.size());
    else begin
      passed++;
      total++;
      if ({addr1_log[0], addr1_log[1]} !== {32'hFFFF_FFFF, 32'd0})
        $display("FAIL wrap_addr1_seq got %h,%h required ffffffff,00000000", addr1_log[0], addr1_log[1]);
      else passed++;
    end
    total++;
    if (bus.busy !== 1'b0) $display("FAIL wrap_busy_end got %b required 0", bus.busy);
    else passed++;
    total++;
    if (exp_q.size() !== 0) $display("FAIL wrap_sb_left got %0d required 0", exp_q.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
`ifdef HHT_PERF_EN
    test_perf_clear();
`endif
    test_zero();
    test_abort();
    test_busy_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
